// File: rtl/flit_sink_rr.sv
// Multi-VC flit sink: per-VC FIFOs drained round-robin under an LFSR throttle, with credit return,
// framing checks, saturating statistics and sticky errors. Define FLIT_SINK_SEQ_CHECK_EN for head sequence checking.
module flit_sink_rr #(
    parameter int          num_vcs            = 4,
    parameter int          buffer_size_per_vc = 4,
    parameter int          flit_data_width    = 64,
    parameter int          consume_rate       = 1024,
    parameter logic [15:0] lfsr_seed          = 16'hACE1,
    parameter int          max_payload_length = 4,
    parameter int          count_width        = 32,
    localparam int         vc_idx_width       = (num_vcs > 1) ? $clog2(num_vcs) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flit_valid_in,
    input  logic [vc_idx_width-1:0]    flit_vc_in,
    input  logic                       flit_head_in,
    input  logic                       flit_tail_in,
    input  logic [flit_data_width-1:0] flit_data_in,
    output logic                       flow_ctrl_valid_out,
    output logic [vc_idx_width-1:0]    flow_ctrl_vc_out,
    output logic [count_width-1:0]     pkt_count,
    output logic [count_width-1:0]     flit_count,
    output logic [3:0]                 error_code,
    output logic                       error
);

    localparam int ptr_width   = (buffer_size_per_vc > 1) ? $clog2(buffer_size_per_vc) : 1;
    localparam int occ_width   = $clog2(buffer_size_per_vc + 1);
    localparam int body_width  = $clog2(max_payload_length + 2);
    localparam int entry_width = flit_data_width + 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OPEN = 1'b1;

    localparam logic [body_width-1:0] body_limit = body_width'(max_payload_length);
    localparam logic [body_width-1:0] body_sat   = body_width'(max_payload_length + 1);

    logic [15:0]               lfsr_reg;
    logic                      consume;
    logic [num_vcs-1:0]        not_empty;
    logic [num_vcs-1:0]        overflow;
    logic [entry_width-1:0]    head_entry [num_vcs];
    logic [vc_idx_width-1:0]   rr_reg;
    logic [vc_idx_width-1:0]   winner;
    logic [vc_idx_width-1:0]   scan_vc;
    int                        scan_idx;
    logic                      any_ready;
    logic                      pop;
    logic [entry_width-1:0]    pop_entry;
    logic                      pop_head;
    logic                      pop_tail;
    logic [flit_data_width-1:0] pop_data;

    logic [0:0]                state_reg    [num_vcs];
    logic [body_width-1:0]     body_cnt_reg [num_vcs];
    logic [0:0]                state_next;
    logic [body_width-1:0]     body_next;
    logic                      err_no_head;
    logic                      err_nested;
    logic                      err_length;

    logic [3:0]                error_code_reg;
    logic [3:0]                error_code_next;
    logic                      error_reg;
    logic                      fc_valid_reg;
    logic [vc_idx_width-1:0]   fc_vc_reg;
    logic [count_width-1:0]    pkt_count_reg;
    logic [count_width-1:0]    flit_count_reg;

    // Fibonacci LFSR, taps 16,14,13,11; throttle decision uses the current value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr_reg <= lfsr_seed;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign consume = ({22'd0, lfsr_reg[9:0]} < 32'(consume_rate));

    for (genvar gi = 0; gi < num_vcs; gi++) begin : g_vc
        logic [entry_width-1:0] mem_reg [buffer_size_per_vc];
        logic [ptr_width-1:0]   rd_ptr_reg;
        logic [ptr_width-1:0]   wr_ptr_reg;
        logic [occ_width-1:0]   occ_reg;
        logic                   sel;
        logic                   full;
        logic                   push_en;
        logic                   pop_en;

        assign sel             = flit_valid_in && (flit_vc_in == vc_idx_width'(gi));
        assign full            = (occ_reg == occ_width'(buffer_size_per_vc));
        assign pop_en          = pop && (winner == vc_idx_width'(gi));
        // A full FIFO still accepts a push when it is popped in the same cycle.
        assign push_en         = sel && (!full || pop_en);
        assign overflow[gi]    = sel && full && !pop_en;
        assign not_empty[gi]   = (occ_reg != '0);
        assign head_entry[gi]  = mem_reg[rd_ptr_reg];

        always_ff @(posedge clk) begin
            if (push_en) begin
                mem_reg[wr_ptr_reg] <= {flit_head_in, flit_tail_in, flit_data_in};
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
                occ_reg    <= '0;
            end else begin
                if (push_en) begin
                    wr_ptr_reg <= (wr_ptr_reg == ptr_width'(buffer_size_per_vc - 1)) ? '0 : wr_ptr_reg + 1'b1;
                end
                if (pop_en) begin
                    rd_ptr_reg <= (rd_ptr_reg == ptr_width'(buffer_size_per_vc - 1)) ? '0 : rd_ptr_reg + 1'b1;
                end
                if (push_en && !pop_en) begin
                    occ_reg <= occ_reg + 1'b1;
                end else if (pop_en && !push_en) begin
                    occ_reg <= occ_reg - 1'b1;
                end
            end
        end
    end

    always_comb begin
        winner    = rr_reg;
        any_ready = 1'b0;
        scan_idx  = 0;
        scan_vc   = '0;
        for (int i = 0; i < num_vcs; i++) begin
            scan_idx = (int'(rr_reg) + i) % num_vcs;
            scan_vc  = vc_idx_width'(scan_idx);
            if (!any_ready && not_empty[scan_vc]) begin
                any_ready = 1'b1;
                winner    = scan_vc;
            end
        end
    end

    assign pop       = consume && any_ready;
    assign pop_entry = head_entry[winner];
    assign pop_head  = pop_entry[entry_width-1];
    assign pop_tail  = pop_entry[entry_width-2];
    assign pop_data  = pop_entry[flit_data_width-1:0];

`ifdef FLIT_SINK_SEQ_CHECK_EN
    logic [7:0] seq_reg [num_vcs];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < num_vcs; i++) begin
                seq_reg[i] <= '0;
            end
        end else if (pop && pop_tail) begin
            seq_reg[winner] <= seq_reg[winner] + 1'b1;
        end
    end
`endif

    always_comb begin
        state_next  = state_reg[winner];
        body_next   = body_cnt_reg[winner];
        err_no_head = 1'b0;
        err_nested  = 1'b0;
        err_length  = 1'b0;
        if (pop) begin
            if (state_reg[winner] == IDLE) begin
                if (pop_head) begin
                    state_next = pop_tail ? IDLE : OPEN;
                    body_next  = '0;
                end else begin
                    err_no_head = 1'b1;
                end
            end else if (pop_head) begin
                // A head inside an open packet abandons the old one and starts afresh.
                err_nested = 1'b1;
                state_next = pop_tail ? IDLE : OPEN;
                body_next  = '0;
            end else begin
                if (body_cnt_reg[winner] != body_sat) begin
                    body_next = body_cnt_reg[winner] + 1'b1;
                end
                err_length = (body_next > body_limit);
                if (pop_tail) begin
                    state_next = IDLE;
                end
            end
        end
`ifdef FLIT_SINK_SEQ_CHECK_EN
        if (pop && pop_head && (pop_data[7:0] != seq_reg[winner])) begin
            err_length = 1'b1;
        end
`endif
    end

    assign error_code_next = error_code_reg | {err_length, err_nested, err_no_head, |overflow};

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_reg         <= '0;
            fc_valid_reg   <= 1'b0;
            fc_vc_reg      <= '0;
            pkt_count_reg  <= '0;
            flit_count_reg <= '0;
            error_code_reg <= '0;
            error_reg      <= 1'b0;
            for (int i = 0; i < num_vcs; i++) begin
                state_reg[i]    <= IDLE;
                body_cnt_reg[i] <= '0;
            end
        end else begin
            error_code_reg <= error_code_next;
            error_reg      <= |error_code_next;
            fc_valid_reg   <= pop;
            if (pop) begin
                fc_vc_reg            <= winner;
                rr_reg               <= (winner == vc_idx_width'(num_vcs - 1)) ? '0 : winner + 1'b1;
                state_reg[winner]    <= state_next;
                body_cnt_reg[winner] <= body_next;
                if (flit_count_reg != '1) begin
                    flit_count_reg <= flit_count_reg + 1'b1;
                end
                if (pop_tail && (pkt_count_reg != '1)) begin
                    pkt_count_reg <= pkt_count_reg + 1'b1;
                end
            end
        end
    end

    assign flow_ctrl_valid_out = fc_valid_reg;
    assign flow_ctrl_vc_out    = fc_vc_reg;
    assign pkt_count           = pkt_count_reg;
    assign flit_count          = flit_count_reg;
    assign error_code          = error_code_reg;
    assign error               = error_reg;

endmodule

// File: tb/tb_flit_sink_rr.sv
// Directed bench for flit_sink_rr: three instances (always-drain, never-drain, and a half-rate
// instance whose seed gives 7 idle throttle cycles after reset, then 6 drain cycles).
module tb_flit_sink_rr;

    logic        clk;
    logic        reset;
    logic        flit_valid_in;
    logic [1:0]  flit_vc_in;
    logic        flit_head_in;
    logic        flit_tail_in;
    logic [63:0] flit_data_in;

    logic        a_fc_valid, z_fc_valid, c_fc_valid;
    logic [1:0]  a_fc_vc, z_fc_vc, c_fc_vc;
    logic [31:0] a_pkt, z_pkt, c_pkt;
    logic [31:0] a_flit, z_flit, c_flit;
    logic [3:0]  a_ec, z_ec, c_ec;
    logic        a_err, z_err, c_err;

    int checks = 0;
    int errors = 0;

    flit_sink_rr #(.consume_rate(1024)) u_a (
        .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in), .flit_data_in(flit_data_in),
        .flow_ctrl_valid_out(a_fc_valid), .flow_ctrl_vc_out(a_fc_vc), .pkt_count(a_pkt),
        .flit_count(a_flit), .error_code(a_ec), .error(a_err)
    );

    flit_sink_rr #(.consume_rate(0)) u_z (
        .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in), .flit_data_in(flit_data_in),
        .flow_ctrl_valid_out(z_fc_valid), .flow_ctrl_vc_out(z_fc_vc), .pkt_count(z_pkt),
        .flit_count(z_flit), .error_code(z_ec), .error(z_err)
    );

    // Seed FFF8 with rate 512: lfsr bit 9 is 1 for states 0..6 and 0 for states 7..12.
    flit_sink_rr #(.consume_rate(512), .lfsr_seed(16'hFFF8)) u_c (
        .clk(clk), .reset(reset), .flit_valid_in(flit_valid_in), .flit_vc_in(flit_vc_in),
        .flit_head_in(flit_head_in), .flit_tail_in(flit_tail_in), .flit_data_in(flit_data_in),
        .flow_ctrl_valid_out(c_fc_valid), .flow_ctrl_vc_out(c_fc_vc), .pkt_count(c_pkt),
        .flit_count(c_flit), .error_code(c_ec), .error(c_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] vc, input logic h, input logic t, input logic [63:0] d);
        flit_valid_in = 1'b1;
        flit_vc_in    = vc;
        flit_head_in  = h;
        flit_tail_in  = t;
        flit_data_in  = d;
        step();
        $display("push vc=%0d head=%0b tail=%0b data=%0h", vc, h, t, d);
    endtask

    task automatic idle();
        flit_valid_in = 1'b0;
        step();
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        flit_valid_in = 1'b0;
        step();
        step();
    endtask

    logic [1:0] rr_push [6];
    logic [1:0] rr_exp  [6];

    initial begin
        reset         = 1'b0;
        flit_valid_in = 1'b0;
        flit_vc_in    = '0;
        flit_head_in  = 1'b0;
        flit_tail_in  = 1'b0;
        flit_data_in  = '0;
        rr_push = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd0, 2'd0};
        rr_exp  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

        // Reset state
        step();
        step();
        check("rst_fc_valid", a_fc_valid, 0);
        check("rst_fc_vc", a_fc_vc, 0);
        check("rst_pkt", a_pkt, 0);
        check("rst_flit", a_flit, 0);
        check("rst_ec", a_ec, 0);
        check("rst_err", a_err, 0);

        // One 3-flit packet on VC2, full drain rate
        reset = 1'b1;
        push(2'd2, 1'b1, 1'b0, 64'h11);
        check("t1_c1_fc_valid", a_fc_valid, 0);
        push(2'd2, 1'b0, 1'b0, 64'h22);
        check("t1_c2_fc_valid", a_fc_valid, 1);
        check("t1_c2_fc_vc", a_fc_vc, 2);
        push(2'd2, 1'b0, 1'b1, 64'h33);
        check("t1_c3_fc_valid", a_fc_valid, 1);
        check("t1_c3_fc_vc", a_fc_vc, 2);
        idle();
        check("t1_c4_fc_valid", a_fc_valid, 1);
        check("t1_c4_fc_vc", a_fc_vc, 2);
        check("t1_pkt", a_pkt, 1);
        check("t1_flit", a_flit, 3);
        idle();
        check("t1_c5_fc_valid", a_fc_valid, 0);
        check("t1_c5_fc_vc_hold", a_fc_vc, 2);
        check("t1_err", a_err, 0);
        check("t1_ec", a_ec, 0);

        // Overflow: 5 flits into a depth-4 VC0 that never drains
        do_reset();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push(2'd0, 1'b1, 1'b1, 64'(k));
            check("ovf_no_credit", z_fc_valid, 0);
            if (k == 3) check("ovf_ec_before", z_ec, 4'b0000);
        end
        check("ovf_ec", z_ec, 4'b0001);
        check("ovf_err", z_err, 1);
        check("ovf_c_ec", c_ec, 4'b0001);
        idle();
        check("ovf_flit", z_flit, 0);
        check("ovf_end_no_credit", z_fc_valid, 0);

        // Round-robin drain: VCs 3,1,0 each loaded with 2 flits before draining starts
        do_reset();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push(rr_push[k], 1'b1, 1'b1, 64'(k));
            check("rr_fill_no_credit", c_fc_valid, 0);
        end
        idle();
        check("rr_wait_no_credit", c_fc_valid, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            $display("drain %0d credit valid=%0b vc=%0d", k, c_fc_valid, c_fc_vc);
            check("rr_credit_valid", c_fc_valid, 1);
            check("rr_credit_vc", c_fc_vc, rr_exp[k]);
        end
        step();
        check("rr_end_valid", c_fc_valid, 0);
        check("rr_pkt", c_pkt, 6);
        check("rr_flit", c_flit, 6);
        check("rr_err", c_err, 0);

        // Framing errors on VC1
        do_reset();
        reset = 1'b1;
        push(2'd1, 1'b0, 1'b0, 64'h0);
        idle();
        check("frm_nohead_ec", a_ec, 4'b0010);
        check("frm_nohead_vc", a_fc_vc, 1);
        push(2'd1, 1'b1, 1'b0, 64'h0);
        idle();
        check("frm_h1_ec", a_ec, 4'b0010);
        push(2'd1, 1'b1, 1'b0, 64'h0);
        idle();
        check("frm_h2_ec", a_ec, 4'b0110);
        check("frm_h2_err", a_err, 1);
        push(2'd1, 1'b1, 1'b0, 64'h0);
        idle();
        for (int b = 1; b <= 5; b++) begin
            push(2'd1, 1'b0, 1'b0, 64'(b));
            idle();
            check("frm_body_ec", a_ec, (b == 5) ? 4'b1110 : 4'b0110);
        end

        // Reset with a partial packet buffered
        do_reset();
        reset = 1'b1;
        push(2'd2, 1'b1, 1'b0, 64'h5);
        push(2'd2, 1'b0, 1'b0, 64'h6);
        idle();
        check("mid_flit_before", a_flit, 2);
        reset = 1'b0;
        step();
        check("mid_fc_valid", a_fc_valid, 0);
        check("mid_fc_vc", a_fc_vc, 0);
        check("mid_pkt", a_pkt, 0);
        check("mid_flit", a_flit, 0);
        check("mid_ec", a_ec, 0);
        check("mid_err", a_err, 0);
        reset = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            check("mid_no_credit", c_fc_valid, 0);
        end
        check("mid_c_flit", c_flit, 0);

`ifdef FLIT_SINK_SEQ_CHECK_EN
        // Head sequence numbers 0 then 2 on VC0
        do_reset();
        reset = 1'b1;
        push(2'd0, 1'b1, 1'b0, 64'h0);
        push(2'd0, 1'b0, 1'b1, 64'h0);
        idle();
        check("seq_ok_ec", a_ec, 4'b0000);
        push(2'd0, 1'b1, 1'b0, 64'h2);
        idle();
        check("seq_bad_ec", a_ec, 4'b1000);
        check("seq_bad_err", a_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
